imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side initiator for the 32x32 instruction/data memory. The fetch path only ever reads that memory; this block is what fills it.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them to consecutive memory addresses from a programmable base.
- Then reads the same range back through the memory's 2-cycle read path and checks an additive checksum.
- Sits between the testbench/boot source and the memory's clk/address/datain/mode/data_out port.

Parameters:
- AW, 5, memory address width; depth is 2^AW words.
- DW, 32, data word width.
- RD_LAT, 2, cycles from presenting a read address (mode=1) to the word appearing on mem_rdata.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; ignored unless busy=0.
- base_addr  in  AW  first address written; sampled on accepted start.
- word_count  in  AW+1  number of words, 0..32; sampled on accepted start.
- in_valid  in  1  input word present.
- in_data  in  DW  input word.
- in_ready  out  1  loader accepts in_data this cycle.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_mode  out  1  1 = read, 0 = write. Matches the memory's mode encoding.
- mem_rdata  in  DW  memory data_out.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at end of operation.
- pass  out  1  checksum matched; valid from done until next accepted start.
- words_written  out  AW+1  count of words written in current/last operation.

Behaviour:
- Reset values (async, rst_n=0):
  - in_ready=0, mem_mode=1, mem_addr=0, mem_wdata=0, busy=0, done=0, pass=0, words_written=0.
  - Checksums cleared; state=IDLE.
- mem_mode is driven 0 only in a cycle where a word is being written. The memory writes on every clock with mode=0, so any other value of mem_mode=0 is a defect.
- Checksums are DW-bit sums, modulo 2^DW (carry discarded).
- Addresses increment modulo 2^AW. Example: base 30, count 4 writes 30, 31, 0, 1.
- FSM states: IDLE, LOAD, VERIFY, DRAIN, DONE.
- IDLE:
  - On start=1 and word_count=0: go to DONE with pass=1, words_written=0.
  - On start=1 and word_count>0: latch base/count, clear sums and words_written, set busy=1, go to LOAD.
- LOAD:
  - in_ready=1.
  - When in_valid&&in_ready (registered outputs):
    - Next cycle: mem_mode=0, mem_addr=current addr, mem_wdata=in_data.
    - wsum += in_data; addr++; words_written++.
  - In cycles without a handshake, mem_mode returns to 1.
  - After the count-th handshake: in_ready drops in the same edge, addr reloads base, go to VERIFY.
  - Exactly word_count handshakes are accepted. The final write cycle is still issued (mem_mode=0 one cycle after the last handshake) before VERIFY starts driving reads.
- VERIFY:
  - mem_mode=1; present addr base..base+count-1, one per cycle.
  - A read-valid shift register of depth RD_LAT tracks issued reads.
  - When the tap asserts, rsum += mem_rdata.
  - After the last address is issued, go to DRAIN.
- DRAIN:
  - Wait until the shift register is empty (RD_LAT cycles).
  - Then pass <= (rsum==wsum); go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy=1 is ignored, with no effect on state or latched values.
- in_valid outside LOAD is ignored; in_ready=0 there.
- rst_n low mid-operation:
  - Abort immediately to reset values. mem_mode=1 asynchronously, so no further writes.
  - Partially written memory is left as is.
- Latency for count N with in_valid held high: start accepted at cycle 0, done pulses at cycle N + 1 + N + RD_LAT + 2 (±1 per implementation, fixed and documented in RTL header).

Test Plan:
- Basic load: base=12, count=4, stream 0x9, 0x6, 0x2, 0x4 with in_valid continuous.
  - Exactly 4 mem_mode=0 cycles, to addresses 12..15 with those data.
  - Reads 12..15; done pulses once; pass=1; words_written=4.
- Backpressure/gaps: count=3, in_valid toggled 1,0,0,1,0,1.
  - Writes occur only after handshakes.
  - mem_mode=1 in gap cycles.
  - Same addresses/data as the gap-free case.
- Wrap-around: base=30, count=4, data 0xA..0xD.
  - Writes to 30, 31, 0, 1; pass=1.
- Corruption: bench memory model flips bit 0 of the word at address 13 on readback.
  - pass=0 at done; words_written=4.
- Edge counts:
  - count=0: done in ≤2 cycles, pass=1, no mem_mode=0 ever.
  - count=32, base=0: all 32 addresses written once; pass=1.
- Reset/start abuse:
  - start pulsed during LOAD is ignored.
  - rst_n asserted after 2 of 4 words: mem_mode=1, busy=0 and in_ready=0 immediately.
  - A new start after reset runs cleanly to pass=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// ============================================================================
// Module   : imem_loader_if
// Brief    : Input word stream and memory port bundle for imem_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface imem_loader_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_mode;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  in_valid, in_data, mem_rdata,
    output in_ready, mem_addr, mem_wdata, mem_mode
  );

  modport slave (
    output in_valid, in_data, mem_rdata,
    input  in_ready, mem_addr, mem_wdata, mem_mode
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Streams words into the instruction memory, then reads the range
//            back and compares additive checksums. For N>0 words with
//            in_valid held high, done pulses in cycle 2N+5 after the edge
//            that accepts start; N=0 finishes in cycle 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module imem_loader #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  imem_loader_if.master bus,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   words_written
);

  localparam logic [2:0]  c_IDLE   = 3'd0;
  localparam logic [2:0]  c_LOAD   = 3'd1;
  localparam logic [2:0]  c_VERIFY = 3'd2;
  localparam logic [2:0]  c_DRAIN  = 3'd3;
  localparam logic [2:0]  c_DONE   = 3'd4;
  localparam logic [AW:0] c_ONE    = {{AW{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [AW-1:0]     r_base;
  logic [AW-1:0]     r_addr;
  logic [AW-1:0]     r_mem_addr;
  logic [AW:0]       r_count;
  logic [AW:0]       r_words_written;
  logic [AW:0]       r_rd_left;
  logic [DW-1:0]     r_wsum;
  logic [DW-1:0]     r_rsum;
  logic [DW-1:0]     r_mem_wdata;
  logic              r_in_ready;
  logic              r_mem_mode;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_rd_issue;
  logic [RD_LAT-1:0] r_rd_vld;

  logic              w_accept;
  logic              w_hs;
  logic              w_last_hs;
  logic              w_drained;
  logic [RD_LAT:0]   w_vld_shift;

  assign w_accept    = start && !r_busy;
  assign w_hs        = bus.in_valid && r_in_ready;
  assign w_last_hs   = w_hs && ((r_words_written + c_ONE) == r_count);
  // r_rd_issue marks a read address currently on the bus; the tap lines up with its data
  assign w_vld_shift = {r_rd_vld, r_rd_issue};
  assign w_drained   = !r_rd_issue && (r_rd_vld == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= c_IDLE;
      r_base          <= '0;
      r_addr          <= '0;
      r_mem_addr      <= '0;
      r_count         <= '0;
      r_words_written <= '0;
      r_rd_left       <= '0;
      r_wsum          <= '0;
      r_rsum          <= '0;
      r_mem_wdata     <= '0;
      r_in_ready      <= 1'b0;
      r_mem_mode      <= 1'b1;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_rd_issue      <= 1'b0;
      r_rd_vld        <= '0;
    end else begin
      r_mem_mode <= 1'b1;
      r_done     <= 1'b0;
      r_rd_issue <= 1'b0;
      r_rd_vld   <= w_vld_shift[RD_LAT-1:0];
      if (r_rd_vld[RD_LAT-1]) begin
        r_rsum <= r_rsum + bus.mem_rdata;
      end

      if (w_accept) begin
        r_pass          <= 1'b0;
        r_words_written <= '0;
        r_wsum          <= '0;
        r_rsum          <= '0;
        r_base          <= base_addr;
        r_addr          <= base_addr;
        r_count         <= word_count;
        if (word_count == '0) begin
          r_pass  <= 1'b1;
          r_done  <= 1'b1;
          r_state <= c_DONE;
        end else begin
          r_busy     <= 1'b1;
          r_in_ready <= 1'b1;
          r_state    <= c_LOAD;
        end
      end else begin
        case (r_state)
          c_LOAD: begin
            if (w_hs) begin
              r_mem_mode      <= 1'b0;
              r_mem_addr      <= r_addr;
              r_mem_wdata     <= bus.in_data;
              r_wsum          <= r_wsum + bus.in_data;
              r_addr          <= r_addr + 1'b1;
              r_words_written <= r_words_written + c_ONE;
              // The final write still goes out next cycle while reads start behind it
              if (w_last_hs) begin
                r_in_ready <= 1'b0;
                r_addr     <= r_base;
                r_rd_left  <= r_count;
                r_state    <= c_VERIFY;
              end
            end
          end
          c_VERIFY: begin
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + 1'b1;
            r_rd_issue <= 1'b1;
            r_rd_left  <= r_rd_left - c_ONE;
            if (r_rd_left == c_ONE) begin
              r_state <= c_DRAIN;
            end
          end
          c_DRAIN: begin
            if (w_drained) begin
              r_pass  <= (r_rsum == r_wsum);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= c_DONE;
            end
          end
          c_DONE:  r_state <= c_IDLE;
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_mode  = r_mem_mode;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign words_written = r_words_written;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed self-checking bench for imem_loader with a 2-cycle
//            read-latency memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_imem_loader;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   words_written;

  imem_loader_if #(.AW(AW), .DW(DW)) bus ();

  imem_loader #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .busy(busy), .done(done),
    .pass(pass), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Memory model: write on every clock with mode=0, data two cycles after the address
  logic [DW-1:0] mem [0:31];
  logic [DW-1:0] s1 = '0;
  logic [DW-1:0] s2 = '0;
  bit            corrupt = 1'b0;
  assign bus.mem_rdata = s2;

  always @(posedge clk) begin
    if (bus.mem_mode == 1'b0) mem[bus.mem_addr] <= bus.mem_wdata;
    s1 <= mem[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 5'd13) ? 32'h1 : 32'h0);
    s2 <= s1;
  end

  int            wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            bad_wr = 0;
  bit            hs_prev = 1'b0;

  // A write must appear exactly in the cycle after each handshake
  always @(negedge clk) begin
    if (bus.mem_mode === 1'b0) begin
      wr_addr_q.push_back(int'(bus.mem_addr));
      wr_data_q.push_back(bus.mem_wdata);
      if (!hs_prev) bad_wr++;
    end else if (hs_prev) begin
      bad_wr++;
    end
    hs_prev = bus.in_valid && bus.in_ready;
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] src [0:31];

  task automatic run_op(input logic [4:0] b, input logic [5:0] n, input bit gaps,
                        input bit abuse, output int done_cyc, output int ndone,
                        output int base_idx);
    int          idx;
    bit          hs;
    logic [5:0]  pat;
    pat      = 6'b101001;
    base_idx = wr_addr_q.size();
    ndone    = 0;
    done_cyc = -1;
    idx      = 0;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (abuse && cyc == 2) begin
        start = 1'b1; base_addr = 5'd0; word_count = 6'd1;
      end else begin
        start = 1'b0;
      end
      bus.in_valid = (idx < int'(n)) && (!gaps || pat[(cyc-1)%6]);
      bus.in_data  = src[idx & 31];
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (hs) idx++;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.in_ready, bus.mem_mode, busy, done, pass} !== 5'b01000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 01000", {bus.in_ready, bus.mem_mode, busy, done, pass});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata, words_written} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %0d wdata %h ww %0d want all 0", bus.mem_addr, bus.mem_wdata, words_written);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input string nm, input logic [4:0] b, input bit gaps,
                            input bit abuse, input int n, input int exp_dc);
    int dc, nd, bi, bw0;
    bit ok;
    bw0 = bad_wr;
    run_op(b, 6'(n), gaps, abuse, dc, nd, bi);
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", nm, nd); end
    n_tests++;
    if (dc !== exp_dc) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, dc, exp_dc); end
    n_tests++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL %s_pass: got %b want 1", nm, pass); end
    n_tests++;
    if (words_written !== 6'(n)) begin n_fail++; $display("FAIL %s_words: got %0d want %0d", nm, words_written, n); end
    ok = (wr_addr_q.size() - bi == n);
    if (ok) for (int i = 0; i < n; i++)
      if (wr_addr_q[bi+i] != ((int'(b) + i) % 32) || wr_data_q[bi+i] !== src[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL %s_writes: got %0d writes want %0d to base %0d", nm, wr_addr_q.size() - bi, n, b); end
    n_tests++;
    if (bad_wr !== bw0) begin n_fail++; $display("FAIL %s_write_timing: got %0d stray/missing want 0", nm, bad_wr - bw0); end
  endtask

  task automatic test_corrupt();
    int dc, nd, bi;
    src[0] = 32'h9; src[1] = 32'h6; src[2] = 32'h2; src[3] = 32'h4;
    corrupt = 1'b1;
    run_op(5'd12, 6'd4, 1'b0, 1'b0, dc, nd, bi);
    corrupt = 1'b0;
    n_tests++;
    if (nd !== 1) begin n_fail++; $display("FAIL corrupt_done_count: got %0d want 1", nd); end
    n_tests++;
    if (pass !== 1'b0) begin n_fail++; $display("FAIL corrupt_pass: got %b want 0", pass); end
    n_tests++;
    if (words_written !== 6'd4) begin n_fail++; $display("FAIL corrupt_words: got %0d want 4", words_written); end
  endtask

  task automatic test_zero();
    int dc, nd, bi;
    run_op(5'd7, 6'd0, 1'b0, 1'b0, dc, nd, bi);
    n_tests++;
    if (nd !== 1 || dc < 1 || dc > 2) begin n_fail++; $display("FAIL zero_done: got %0d pulses at cycle %0d want 1 within 2", nd, dc); end
    n_tests++;
    if (pass !== 1'b1) begin n_fail++; $display("FAIL zero_pass: got %b want 1", pass); end
    n_tests++;
    if (words_written !== 6'd0) begin n_fail++; $display("FAIL zero_words: got %0d want 0", words_written); end
    n_tests++;
    if (wr_addr_q.size() != bi) begin n_fail++; $display("FAIL zero_no_write: got %0d writes want 0", wr_addr_q.size() - bi); end
  endtask

  task automatic test_reset_mid();
    int dc, nd, bi;
    src[0] = 32'h9; src[1] = 32'h6; src[2] = 32'h2; src[3] = 32'h4;
    start = 1'b1; base_addr = 5'd12; word_count = 6'd4;
    @(posedge clk); #1;
    start = 1'b0; bus.in_valid = 1'b1; bus.in_data = src[0];
    @(posedge clk); #1;
    bus.in_data = src[1];
    @(posedge clk); #1;
    bus.in_data = src[2];
    n_tests++;
    if (bus.mem_mode !== 1'b0 || bus.mem_addr !== 5'd13) begin
      n_fail++; $display("FAIL mid_second_write: got mode %b addr %0d want 0 13", bus.mem_mode, bus.mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.mem_mode, busy, bus.in_ready} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_abort: got %b want 100", {bus.mem_mode, busy, bus.in_ready});
    end
    n_tests++;
    if (words_written !== 6'd0) begin n_fail++; $display("FAIL mid_reset_words: got %0d want 0", words_written); end
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(5'd12, 6'd4, 1'b0, 1'b0, dc, nd, bi);
    n_tests++;
    if (nd !== 1 || pass !== 1'b1) begin n_fail++; $display("FAIL mid_restart: got %0d pulses pass %b want 1 1", nd, pass); end
    n_tests++;
    if (words_written !== 6'd4) begin n_fail++; $display("FAIL mid_restart_words: got %0d want 4", words_written); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    src[0] = 32'h9; src[1] = 32'h6; src[2] = 32'h2; src[3] = 32'h4;
    test_basic("basic", 5'd12, 1'b0, 1'b0, 4, 13);
    // Handshakes land in cycles 1, 4 and 6, so done follows the last one by N+5
    test_basic("gaps", 5'd12, 1'b1, 1'b0, 3, 14);
    src[0] = 32'hA; src[1] = 32'hB; src[2] = 32'hC; src[3] = 32'hD;
    test_basic("wrap", 5'd30, 1'b0, 1'b0, 4, 13);
    test_corrupt();
    test_zero();
    for (int i = 0; i < 32; i++) src[i] = 32'h1000_0001 * (i + 1) + 32'hF000_0000;
    test_basic("full", 5'd0, 1'b0, 1'b0, 32, 69);
    src[0] = 32'h9; src[1] = 32'h6; src[2] = 32'h2; src[3] = 32'h4;
    test_basic("start_abuse", 5'd12, 1'b0, 1'b1, 4, 13);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
